// File: rtl/systolic_host_ctrl.sv
// Host-side job controller for systolic_array: snapshots an operand pair, streams A then B
// into the array one beat every other cycle, flushes, and collects the product elements.
module systolic_host_ctrl #(
   parameter int width_p        = 8,
   parameter int array_width_p  = 2,
   parameter int array_height_p = 2,
   parameter int timeout_p      = 64
) (
   input  logic                                              clk_i,
   input  logic                                              reset_i,
   input  logic                                              start_i,
   input  logic [width_p*array_width_p*array_height_p-1:0] op_a_i,
   input  logic [width_p*array_width_p*array_height_p-1:0] op_b_i,
   output logic                                              busy_o,
   output logic                                              done_o,
   output logic                                              error_o,
   output logic [width_p*array_width_p*array_height_p-1:0] result_o,
   output logic                                              arr_valid_o,
   output logic [width_p-1:0]                                arr_data_o,
   input  logic                                              arr_ready_i,
   output logic                                              arr_flush_o,
   input  logic                                              arr_valid_i,
   input  logic [width_p-1:0]                                arr_data_i,
   output logic                                              arr_yumi_o
);

   localparam int elems_lp = array_width_p * array_height_p;
   localparam int vec_w_lp = width_p * elems_lp;
   localparam int idx_w_lp = $clog2(elems_lp + 1);
   localparam int wd_w_lp  = $clog2(timeout_p + 1);

   localparam logic [idx_w_lp-1:0] elems_idx_lp = idx_w_lp'(elems_lp);
   localparam logic [idx_w_lp-1:0] last_idx_lp  = idx_w_lp'(elems_lp - 1);
   localparam logic [wd_w_lp-1:0]  timeout_lp   = wd_w_lp'(timeout_p);

   typedef enum logic [3:0] {
      IDLE,
      WAIT_A,
      SEND_A,
      GAP_A,
      WAIT_B,
      SEND_B,
      GAP_B,
      WAIT_F,
      FLUSH,
      DRAIN,
      DONE
   } state_e;

   state_e                state_q, state_d;
   logic [vec_w_lp-1:0]   op_a_q, op_a_d;
   logic [vec_w_lp-1:0]   op_b_q, op_b_d;
   logic [vec_w_lp-1:0]   result_q, result_d;
   logic [idx_w_lp-1:0]   idx_q, idx_d;
   logic [wd_w_lp-1:0]    wdog_q, wdog_d;
   logic                  ready_prev_q, ready_prev_d;

   logic                  ready_rise;
   logic                  wdog_active;
   logic                  wdog_expired;
   logic                  capture;
   logic                  last_capture;

   // B and flush wait for a fresh 0->1 of ready, so the array can signal it has absorbed A/B.
   assign ready_prev_d = arr_ready_i;
   assign ready_rise   = arr_ready_i & ~ready_prev_q;
   assign wdog_active  = state_q inside {WAIT_A, WAIT_B, WAIT_F, DRAIN};
   assign wdog_expired = wdog_active && (wdog_q == timeout_lp);
   assign capture      = ((state_q == FLUSH) || (state_q == DRAIN)) && arr_valid_i;
   assign last_capture = capture && (idx_q == last_idx_lp);
   assign result_o     = result_q;

   always_comb begin
      state_d     = state_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      result_d    = result_q;
      idx_d       = idx_q;
      busy_o      = (state_q != IDLE);
      done_o      = 1'b0;
      error_o     = 1'b0;
      arr_valid_o = 1'b0;
      arr_data_o  = '0;
      arr_flush_o = 1'b0;
      arr_yumi_o  = capture;

      if (capture) begin
         result_d[idx_q*width_p +: width_p] = arr_data_i;
         idx_d = idx_q + idx_w_lp'(1);
      end

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               op_a_d  = op_a_i;
               op_b_d  = op_b_i;
               idx_d   = '0;
               state_d = WAIT_A;
            end
         end
         WAIT_A: begin
            if (arr_ready_i) begin
               state_d = SEND_A;
            end
         end
         SEND_A: begin
            arr_valid_o = 1'b1;
            arr_data_o  = op_a_q[idx_q*width_p +: width_p];
            idx_d       = idx_q + idx_w_lp'(1);
            state_d     = GAP_A;
         end
         GAP_A: begin
            if (idx_q < elems_idx_lp) begin
               state_d = SEND_A;
            end else begin
               idx_d   = '0;
               state_d = WAIT_B;
            end
         end
         WAIT_B: begin
            if (ready_rise) begin
               state_d = SEND_B;
            end
         end
         SEND_B: begin
            arr_valid_o = 1'b1;
            arr_data_o  = op_b_q[idx_q*width_p +: width_p];
            idx_d       = idx_q + idx_w_lp'(1);
            state_d     = GAP_B;
         end
         GAP_B: begin
            if (idx_q < elems_idx_lp) begin
               state_d = SEND_B;
            end else begin
               idx_d   = '0;
               state_d = WAIT_F;
            end
         end
         WAIT_F: begin
            if (ready_rise) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            arr_flush_o = 1'b1;
            state_d     = last_capture ? DONE : DRAIN;
         end
         DRAIN: begin
            if (last_capture) begin
               state_d = DONE;
            end
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort wins over any transition; slots already captured stay in the result register.
      if (wdog_expired) begin
         error_o = 1'b1;
         state_d = IDLE;
      end
   end

   always_comb begin
      wdog_d = wdog_q;
      if (state_d != state_q) begin
         wdog_d = '0;
      end else if (wdog_active) begin
         wdog_d = wdog_q + wd_w_lp'(1);
      end
   end

   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q      <= IDLE;
         op_a_q       <= '0;
         op_b_q       <= '0;
         result_q     <= '0;
         idx_q        <= '0;
         wdog_q       <= '0;
         ready_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         result_q     <= result_d;
         idx_q        <= idx_d;
         wdog_q       <= wdog_d;
         ready_prev_q <= ready_prev_d;
      end
   end

endmodule

// File: doc/systolic_host_ctrl.md
# systolic_host_ctrl

Host-side job controller for `systolic_array`. It drives the array's serial operand-load interface (`valid`/`data`, paced by `ready`) and its flush-and-drain result interface (`flush`/`valid`/`yumi`). It captures one packed operand pair per job, streams operand A and then operand B into the array, flushes, collects the product elements into a packed result register, and pulses `done_o`. It sits between a register-file/CSR front end and the array, and replaces hand-sequenced bench stimulus.

## Interface
Parameters:
- `width_p`, 8, element width in bits (operands and results).
- `array_width_p`, 2, array columns.
- `array_height_p`, 2, array rows; `elems = array_width_p*array_height_p`.
- `timeout_p`, 64, maximum cycles spent in any wait or drain state before abort.

Ports:
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-low reset.
- `start_i`  in  1  job request; sampled only in IDLE.
- `op_a_i`  in  `width_p*elems`  operand A; element k at `[k*width_p +: width_p]`, row-major.
- `op_b_i`  in  `width_p*elems`  operand B; same packing.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse when the job completes.
- `error_o`  out  1  one-cycle pulse on watchdog abort.
- `result_o`  out  `width_p*elems`  captured results, same packing; held until overwritten.
- `arr_valid_o`  out  1  operand beat to the array.
- `arr_data_o`  out  `width_p`  operand element.
- `arr_ready_i`  in  1  array ready for an operand.
- `arr_flush_o`  out  1  one-cycle flush request.
- `arr_valid_i`  in  1  array result valid.
- `arr_data_i`  in  `width_p`  array result element.
- `arr_yumi_o`  out  1  result consumed.

## Operation
States: IDLE, WAIT_A, SEND_A, GAP_A, WAIT_B, SEND_B, GAP_B, WAIT_F, FLUSH, DRAIN, DONE.

- **IDLE:**
  - On `start_i`, register `op_a_i`/`op_b_i` into internal snapshots, clear the element index, go to WAIT_A.
  - `start_i` in any other state is ignored.
- **WAIT_A:** on `arr_ready_i`=1 (level), go to SEND_A.
- **SEND_x:**
  - `arr_valid_o`=1 for exactly one cycle, with `arr_data_o` = snapshot element [idx].
  - Increment idx; go to GAP_x.
- **GAP_x:**
  - `arr_valid_o`=0 for one cycle.
  - If idx<elems, go to SEND_x.
  - Otherwise clear idx and go to WAIT_B (from GAP_A) or WAIT_F (from GAP_B).
- **Beat timing:** beats are never back-to-back, and the beat pattern is not gated by `arr_ready_i`.
- **WAIT_B / WAIT_F:**
  - Wait for a rising edge of `arr_ready_i`: current sample 1, previous-cycle sample 0.
  - The previous-sample flop updates every cycle and resets to 1.
  - On the edge, WAIT_B goes to SEND_B and WAIT_F goes to FLUSH.
- **FLUSH:** `arr_flush_o`=1 for one cycle; go to DRAIN.
- **Result capture (FLUSH and DRAIN):**
  - `arr_yumi_o` = `arr_valid_i`, combinationally.
  - Each cycle with `arr_valid_i`=1 writes `arr_data_i` into result slot idx and increments idx.
  - The result in the FLUSH cycle is accepted.
  - On the elems-th capture, go to DONE.
- **DONE:** `done_o`=1 for one cycle; go to IDLE.
- **Watchdog:**
  - The counter clears on every state change.
  - It counts in WAIT_A, WAIT_B, WAIT_F and DRAIN.
  - When it reaches `timeout_p`, pulse `error_o` for one cycle and go to IDLE.
  - An abort produces no `done_o`. `result_o` keeps any slots already written.
- **Arithmetic:** the controller does not compute. Results are stored bit-exact at `width_p` bits; the array owns any wrap/truncation.
- **Result register:** `result_o` is written directly by captures, slot by slot during DRAIN. It is valid as a whole when `done_o` pulses.

## Timing
- **Reset:**
  - `reset_i`=0 at any time forces IDLE immediately, mid-job included.
  - All outputs go to 0, including `result_o`, snapshots, idx and the watchdog.
  - The previous-`arr_ready_i` flop resets to 1.
- **Start latency:** with `start_i` at cycle 0 and `arr_ready_i` already high, the state is WAIT_A at cycle 1 and the first `arr_valid_o` is at cycle 2.
- **Operand duration:** each operand takes 2*elems cycles, from its first beat to the end of its last GAP.
- **WAIT_B:** the earliest SEND_B is the cycle after the rising-edge sample.
- **Flush to done:** `done_o` rises the cycle after the last capture. The minimum flush-to-done is elems cycles when results stream every cycle starting in FLUSH.
- **Result stalls:** gaps in `arr_valid_i` during DRAIN are tolerated (`arr_yumi_o`=0) until the watchdog expires.
- **Outside FLUSH/DRAIN:** `arr_yumi_o` stays 0 even if `arr_valid_i`=1, and nothing is captured.
- **Same-cycle start:** `start_i` in the same cycle as `done_o` is ignored, because the state is DONE, not IDLE.

## Test plan
1. **Nominal job:**
   - Stimulus: 2x2, A={1,2,3,4}, B={1,2,3,4}; the array model returns 7,10,15,22 starting in the FLUSH cycle.
   - Required: beats 1,2,3,4 on alternate cycles, then B's beats after the ready edge; `result_o`={22,15,10,7} (slot3..0); `done_o` one cycle; `busy_o` low after.
2. **Ready pacing:**
   - Stimulus: hold `arr_ready_i` low 5 cycles before A; keep it high with no 0→1 edge after A for 10 cycles.
   - Required: no A beat until ready; no B beat until the edge appears.
3. **Drain stalls:**
   - Stimulus: results arrive with gaps of 0,2,1,3 cycles.
   - Required: exactly 4 captures in order; `arr_yumi_o` mirrors `arr_valid_i` only in FLUSH/DRAIN.
4. **Watchdog:**
   - Stimulus: never raise the B-side ready edge.
   - Required: `error_o` pulses exactly `timeout_p` cycles after WAIT_B entry; returns to IDLE; no `done_o`.
5. **Reset mid-job:**
   - Stimulus: drive `reset_i`=0 during SEND_B.
   - Required: all outputs 0 immediately; a new `start_i` runs a clean job matching scenario 1.
6. **Ignored start:**
   - Stimulus: pulse `start_i` with different operands during SEND_A.
   - Required: the original snapshot is streamed unchanged.
